// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
// Copies the instruction ROM into the writable instruction RAM after reset
// and on every reload request, holding the CPU while the copy runs. The copy
// walks ROM addresses upward from 0. It stops after the word whose opcode is
// the end marker, or after the last address. The CPU is then released and the
// RAM read port is handed to CPU fetch. The word count and a running checksum
// of the copy are kept for self-test.

module imem_boot_ctrl #(
    parameter int              AWIDTH = 8,
    parameter int              DWIDTH = 13,
    parameter int              OPW    = 5,
    parameter logic [OPW-1:0]  END_OP = 5'h1F
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic [AWIDTH-1:0] o_rom_addr,
    input  logic [DWIDTH-1:0] i_rom_data,
    output logic              o_ram_we,
    output logic [AWIDTH-1:0] o_ram_waddr,
    output logic [DWIDTH-1:0] o_ram_wdata,
    input  logic [AWIDTH-1:0] i_cpu_fetch_addr,
    output logic [AWIDTH-1:0] o_ram_raddr,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic [AWIDTH:0]   o_words,
    output logic [DWIDTH-1:0] o_checksum
);

    typedef enum logic {
        ST_COPY = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AWIDTH-1:0] PTR_ONE   = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] PTR_LAST  = '1;
    localparam logic [AWIDTH:0]   WORDS_ONE = (AWIDTH + 1)'(1);

    state_t            r_state;
    logic [AWIDTH-1:0] r_ptr;
    logic [AWIDTH:0]   r_words;
    logic [DWIDTH-1:0] r_checksum;
    logic              r_hold;
    logic              r_done;

    logic [OPW-1:0]    w_opcode;
    logic              w_end_op;
    logic              w_last_addr;
    logic              w_stop;
    logic              w_copy;
    logic              w_run;

    // Opcode of the word being copied; the marker word is written before stopping
    assign w_opcode    = i_rom_data[DWIDTH-1 -: OPW];
    assign w_end_op    = (w_opcode == END_OP);
    assign w_last_addr = (r_ptr == PTR_LAST);
    assign w_stop      = w_end_op || w_last_addr;

    // Reset overrides the state decode so the reset cycle never writes RAM
    assign w_copy = (r_state == ST_COPY) && !i_rst;
    assign w_run  = (r_state == ST_RUN)  && !i_rst;

    // Datapath to ROM/RAM: pointer-driven while copying, CPU-driven read port in RUN
    always_comb begin
        o_ram_we    = w_copy;
        o_ram_waddr = r_ptr;
        o_ram_wdata = i_rom_data;
        o_rom_addr  = w_copy ? r_ptr : '0;
        o_ram_raddr = w_run ? i_cpu_fetch_addr : r_ptr;
    end

    // Status outputs: registered, forced to their reset values while reset is high
    always_comb begin
        o_cpu_hold = r_hold | i_rst;
        o_done     = r_done & ~i_rst;
        o_words    = i_rst ? '0 : r_words;
        o_checksum = i_rst ? '0 : r_checksum;
    end

    // Copy/run sequencer; a reload request in COPY is dropped, not queued
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_COPY;
            r_ptr      <= '0;
            r_words    <= '0;
            r_checksum <= '0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_COPY: begin
                    r_words    <= r_words + WORDS_ONE;
                    r_checksum <= r_checksum + i_rom_data;
                    if (w_stop) begin
                        r_state <= ST_RUN;
                        r_ptr   <= '0;
                        r_hold  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + PTR_ONE;
                    end
                end
                ST_RUN: begin
                    if (i_start) begin
                        r_state    <= ST_COPY;
                        r_ptr      <= '0;
                        r_words    <= '0;
                        r_checksum <= '0;
                        r_hold     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_COPY;
                    r_ptr   <= '0;
                    r_hold  <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Testbench for imem_boot_ctrl: directed scenarios plus randomized ROM
// contents, reload requests and resets, checked every cycle against a
// copy-timeline model (copy start cycle, end address, prefix sums).

module tb_imem_boot_ctrl;

    localparam int AW = 8;
    localparam int DW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] fetch;
    logic [AW-1:0] raddr;
    logic          hold;
    logic          done;
    logic [AW:0]   words;
    logic [DW-1:0] cksum;

    logic [DW-1:0] rom [256];
    assign rom_data = rom[rom_addr];

    imem_boot_ctrl dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start          (start),
        .o_rom_addr       (rom_addr),
        .i_rom_data       (rom_data),
        .o_ram_we         (we),
        .o_ram_waddr      (waddr),
        .o_ram_wdata      (wdata),
        .i_cpu_fetch_addr (fetch),
        .o_ram_raddr      (raddr),
        .o_cpu_hold       (hold),
        .o_done           (done),
        .o_words          (words),
        .o_checksum       (cksum)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // A copy started at cycle m_start writes address k at cycle m_start+k for
    // k = 0..m_end; afterwards the CPU runs with the final count and sum.
    int            m_start = 0;
    int            m_end   = 0;
    logic [DW-1:0] m_rom [256];

    function automatic int find_end();
        for (int a = 0; a < 256; a++)
            if (m_rom[a][12:8] == 5'h1F) return a;
        return 255;
    endfunction

    function automatic logic [DW-1:0] msum(input int k);
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < k; i++) s = s + m_rom[i];
        return s;
    endfunction

    initial begin : compare
        int k;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_we",    we,       0);
                chk("rst_romad", rom_addr, 0);
                chk("rst_hold",  hold,     1);
                chk("rst_done",  done,     0);
                chk("rst_words", words,    0);
                chk("rst_cksum", cksum,    0);
                m_start = cyc + 1;
            end else begin
                k = cyc - m_start;
                if (k == 0) begin
                    m_rom = rom;
                    m_end = find_end();
                end
                if (k <= m_end) begin
                    chk("cp_we",    we,       1);
                    chk("cp_waddr", waddr,    k);
                    chk("cp_wdata", wdata,    m_rom[k]);
                    chk("cp_romad", rom_addr, k);
                    chk("cp_raddr", raddr,    k);
                    chk("cp_hold",  hold,     1);
                    chk("cp_done",  done,     0);
                    chk("cp_words", words,    k);
                    chk("cp_cksum", cksum,    msum(k));
                    if (k == m_end)
                        $display("[TB] copy of %0d words ends at cycle %0d", m_end + 1, cyc);
                end else begin
                    chk("rn_we",    we,       0);
                    chk("rn_romad", rom_addr, 0);
                    chk("rn_raddr", raddr,    fetch);
                    chk("rn_hold",  hold,     0);
                    chk("rn_done",  done,     1);
                    chk("rn_words", words,    m_end + 1);
                    chk("rn_cksum", cksum,    msum(m_end + 1));
                    if (start) m_start = cyc + 1;
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_basic();
        for (int a = 0; a < 256; a++) rom[a] = '0;
        for (int a = 0; a < 7; a++) rom[a] = DW'(a + 1);
        rom[7] = 13'h1F00;
    endtask

    initial begin : driver
        logic [DW-1:0] w;
        int            am;
        rst = 1'b1; start = 1'b0; fetch = '0;
        load_basic();
        step(); step();
        // basic copy, marker at address 7
        rst = 1'b0;
        #1;
        chk("t1_we_c0",   we,    1);
        chk("t1_wa_c0",   waddr, 0);
        repeat (8) step();
        #1;
        chk("t1_done",  done,  1);
        chk("t1_hold",  hold,  0);
        chk("t1_words", words, 9'd8);
        chk("t1_cksum", cksum, 13'h1F1C);
        // CPU fetch path in RUN
        fetch = 8'h05;
        #1;
        chk("fe_raddr", raddr,    8'h05);
        chk("fe_we",    we,       0);
        chk("fe_romad", rom_addr, 0);
        // reload request, with a second request during the copy
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("st_hold",  hold,     1);
        chk("st_done",  done,     0);
        chk("st_romad", rom_addr, 0);
        chk("st_words", words,    0);
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        #1;
        chk("st_done7", done, 0);
        step();
        #1;
        chk("st_done8", done,  1);
        chk("st_words", words, 9'd8);
        chk("st_cksum", cksum, 13'h1F1C);
        // reset in the middle of a copy
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("mr_words", words,    0);
        chk("mr_cksum", cksum,    0);
        chk("mr_hold",  hold,     1);
        chk("mr_we",    we,       0);
        chk("mr_romad", rom_addr, 0);
        step();
        rst = 1'b0;
        #1;
        chk("mr_restart", rom_addr, 0);
        chk("mr_we1",     we,       1);
        repeat (8) step();
        #1;
        chk("mr_done",  done,  1);
        chk("mr_words", words, 9'd8);
        chk("mr_cksum", cksum, 13'h1F1C);
        // no marker: full 256-word copy
        rst = 1'b1;
        for (int a = 0; a < 256; a++) rom[a] = 13'h0001;
        step();
        rst = 1'b0;
        repeat (255) step();
        #1;
        chk("full_done255", done,  0);
        chk("full_wa255",   waddr, 8'hFF);
        chk("full_we255",   we,    1);
        step();
        #1;
        chk("full_done", done,  1);
        chk("full_words", words, 9'h100);
        chk("full_cksum", cksum, 13'h0100);
        // marker at address 0
        rst = 1'b1;
        for (int a = 0; a < 256; a++) rom[a] = '0;
        rom[0] = 13'h1F00;
        step();
        rst = 1'b0;
        #1;
        chk("m0_we",   we,   1);
        chk("m0_done", done, 0);
        step();
        #1;
        chk("m0_done1", done,  1);
        chk("m0_words", words, 9'd1);
        chk("m0_cksum", cksum, 13'h1F00);
        // randomized ROMs, reload requests, resets and fetch addresses
        for (int it = 0; it < 25; it++) begin
            rst = 1'b1;
            for (int a = 0; a < 256; a++) begin
                w = DW'($urandom);
                if (w[12:8] == 5'h1F) w[12] = 1'b0;
                rom[a] = w;
            end
            if ($urandom_range(0, 3) != 0) begin
                am = int'($urandom_range(0, 255) >> $urandom_range(0, 4));
                rom[am] = {5'h1F, 8'($urandom)};
            end
            step();
            rst = 1'b0;
            for (int c = 0; c < 700; c++) begin
                start = ($urandom_range(0, 29) == 0);
                rst   = ($urandom_range(0, 299) == 0);
                fetch = AW'($urandom);
                step();
            end
        end
        rst = 1'b0; start = 1'b0;
        step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
